// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO behind a valid/ready write port feeding a
// frame serialiser with programmable divisor, 5-8 data bits, parity, stop bits and break.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [DIV_WIDTH-1:0]        cfg_div,
    input  logic [1:0]                  cfg_data_bits,
    input  logic                        cfg_stop_bits,
    input  logic                        cfg_parity_en,
    input  logic                        cfg_parity_even,
    input  logic                        tx_en,
    input  logic                        break_req,
    input  logic                        wr_valid,
    input  logic [7:0]                  wr_data,
    output logic                        wr_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        tx_done,
    output logic [2:0]                  dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int OW = $clog2(OVERSAMPLE);
    localparam logic [AW:0]   FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [OW-1:0] OS_LAST    = OW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK
    } state_t;

    state_t               state_q, state_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [7:0]           shreg_q, shreg_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [2:0]           nbits_m1_q, nbits_m1_d;
    logic                 stop2_q, stop2_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [OW-1:0]        os_cnt_q, os_cnt_d;
    logic                 guard_q, guard_d;
    logic                 tx_q, tx_d;

    logic [AW:0] level;
    logic        full, empty, wr_fire, pop, tick, bit_end, running, done;
    logic [7:0]  head, data_mask;

    // Write handshake: a byte is taken when wr_valid && wr_ready; wr_ready is a
    // function of the registered level only, so a pop never frees a slot in the same cycle.
    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign wr_fire = wr_valid && !full;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    assign tick    = (div_cnt_q == div_q);
    assign bit_end = tick && (os_cnt_q == OS_LAST);
    // Bit timers run in every frame state, and in IDLE while the post-break guard bit is pending.
    assign running = (state_q != S_IDLE && state_q != S_BREAK) || (state_q == S_IDLE && guard_q);

    always_comb begin
        case (cfg_data_bits)
            2'b00:   data_mask = 8'h1F;
            2'b01:   data_mask = 8'h3F;
            2'b10:   data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q + LW'(wr_fire);
        rd_ptr_d   = rd_ptr_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        nbits_m1_d = nbits_m1_q;
        stop2_d    = stop2_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        os_cnt_d   = os_cnt_q;
        guard_d    = guard_q;
        pop        = 1'b0;
        done       = 1'b0;

        if (running) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
            if (bit_end)   os_cnt_d = '0;
            else if (tick) os_cnt_d = os_cnt_q + OW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (break_req) begin
                    state_d = S_BREAK;
                    guard_d = 1'b0;
                end else if (guard_q) begin
                    if (bit_end) guard_d = 1'b0;
                end else if (tx_en && !empty) begin
                    // Frame configuration is frozen here for the whole frame.
                    pop        = 1'b1;
                    state_d    = S_START;
                    shreg_d    = head;
                    bit_cnt_d  = '0;
                    nbits_m1_d = {1'b1, cfg_data_bits};
                    stop2_d    = cfg_stop_bits;
                    par_en_d   = cfg_parity_en;
                    par_bit_d  = (^(head & data_mask)) ^ ~cfg_parity_even;
                    div_d      = cfg_div;
                    div_cnt_d  = '0;
                    os_cnt_d   = '0;
                end
            end
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == nbits_m1_q) state_d = par_en_q ? S_PARITY : S_STOP1;
                    else bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            S_PARITY: if (bit_end) state_d = S_STOP1;
            S_STOP1: begin
                if (bit_end) begin
                    if (stop2_q) begin
                        state_d = S_STOP2;
                    end else begin
                        state_d = S_IDLE;
                        done    = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end
            end
            S_BREAK: begin
                // Leaving break arms a full idle bit before any new start bit.
                if (!break_req) begin
                    state_d   = S_IDLE;
                    guard_d   = 1'b1;
                    div_d     = cfg_div;
                    div_cnt_d = '0;
                    os_cnt_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rd_ptr_d = rd_ptr_q + LW'(pop);

        case (state_d)
            S_START, S_BREAK: tx_d = 1'b0;
            S_DATA:           tx_d = shreg_d[0];
            S_PARITY:         tx_d = par_bit_d;
            default:          tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            nbits_m1_q <= '0;
            stop2_q    <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            div_q      <= '0;
            div_cnt_q  <= '0;
            os_cnt_q   <= '0;
            guard_q    <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            nbits_m1_q <= nbits_m1_d;
            stop2_q    <= stop2_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            div_q      <= div_d;
            div_cnt_q  <= div_cnt_d;
            os_cnt_q   <= os_cnt_d;
            guard_q    <= guard_d;
            tx_q       <= tx_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign wr_ready   = !full;
    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || !empty;
    assign fifo_level = level;
    assign tx_done    = done;
    assign dbg_state  = state_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter. It accepts bytes through a valid/ready write port into an internal FIFO and serialises them onto `tx`. It supports a runtime-programmable baud divisor, 5–8 data bits, optional even/odd parity, 1 or 2 stop bits and break generation. It sits between the APB register block, which drives the `cfg_*` inputs and the write port, and the UART pad.

## Interface
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥2.
- `OVERSAMPLE`, 16: baud ticks per bit; ≥2.
- `DIV_WIDTH`, 16: width of `cfg_div`.
- `clk` in 1: single clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_div` in DIV_WIDTH: one baud tick every `cfg_div`+1 clk cycles.
- `cfg_data_bits` in 2: 00=5, 01=6, 10=7, 11=8 data bits.
- `cfg_stop_bits` in 1: 0 selects one stop bit, 1 selects two.
- `cfg_parity_en` in 1: enables the parity bit.
- `cfg_parity_even` in 1: 1 selects even parity, 0 selects odd.
- `tx_en` in 1: permits new frames to start.
- `break_req` in 1: request to hold the line low (break).
- `wr_valid` in 1: write data valid.
- `wr_data` in 8: byte to send, LSB first; unused upper bits ignored.
- `wr_ready` out 1: FIFO not full.
- `tx` out 1: serial output, registered, idle high.
- `busy` out 1: high when the FSM is not in IDLE or the FIFO is not empty.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `tx_done` out 1: one-cycle pulse at the end of each frame.

## Operation
- **Write:** a write is accepted when `wr_valid && wr_ready`. `wr_ready` depends only on the level at the start of the cycle, so a simultaneous pop does not free a slot in the same cycle.
- **FSM states:** IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
- **IDLE:**
  - `tx`=1.
  - Priority 1: if `break_req`=1, go to BREAK.
  - Priority 2: otherwise, if `tx_en`=1 and the FIFO is non-empty, pop the head into the shift register and go to START.
  - On that pop, latch all `cfg_*` for the whole frame; changing them mid-frame has no effect.
  - On that pop, restart the tick divider and the oversample counter from zero.
- **Bit timing:** each of START/DATA/PARITY/STOP1/STOP2 lasts exactly OVERSAMPLE ticks.
- **START:** `tx`=0, then go to DATA.
- **DATA:**
  - `tx` = shift register bit 0.
  - Shift right at the end of each bit.
  - After N bits, go to PARITY if parity is enabled, otherwise STOP1.
- **PARITY:** `tx` = XOR of the N data bits when even, inverted when odd. Result: the total number of ones (data plus parity) is even for even parity and odd for odd parity.
- **STOP1:** `tx`=1. Then go to STOP2 if two stop bits are selected, otherwise end the frame.
- **STOP2:** `tx`=1, then end the frame.
- **End of frame:** pulse `tx_done` and go to IDLE.
- **BREAK:** `tx`=0 while `break_req`=1. On deassertion, return to IDLE with `tx`=1 for at least one full bit time (OVERSAMPLE ticks) before a new START.
- **`break_req` mid-frame:** ignored until the frame completes.
- **`tx_en` deasserted mid-frame:** the current frame completes; no new frame starts.
- **Reset, any time:** FIFO flushed, FSM to IDLE, frame abandoned immediately.
- **FIFO pointers:** wrap modulo FIFO_DEPTH; the extra level bit distinguishes full from empty.

## Timing
- **Reset values:** `tx`=1, `wr_ready`=1, `busy`=0, `fifo_level`=0, `tx_done`=0.
- **Write to level:** accepted write in cycle k gives `fifo_level` +1 in cycle k+1.
- **Write to pop:** the entry can be popped no earlier than cycle k+1.
- **Pop to line:** pop in cycle p gives `tx`=0 from cycle p+1 (registered output).
- **Frame length:** (1+N+P+S) × OVERSAMPLE × (`cfg_div`+1) clk cycles, exact.
  - N = data bits, P = 1 if parity enabled else 0, S = stop bits.
- **`tx_done`:** high for the single cycle in which the last stop bit completes; `tx` is still 1 then.
- **Back-to-back frames:** with the FIFO non-empty and `tx_en`=1, exactly one IDLE cycle separates the last stop cycle from the pop. The next start bit then begins at the following cycle.
- **`cfg_div`=0:** a tick every cycle; a bit lasts OVERSAMPLE clk cycles.
- **Full FIFO:** `wr_ready`=0 when `fifo_level`=FIFO_DEPTH. A write attempted then is dropped with no side effect.
- **Empty FIFO:** no pop; the FSM stays in IDLE.

## Test plan
- **Reset and basic frame.** Stimulus: after reset, write 0x55 with `cfg_div`=0, 8N1, OVERSAMPLE=16. Required response: `tx`=0 for 16 cycles, then bits 1,0,1,0,1,0,1,0, then stop=1. `tx_done` pulses at cycle 160 after the start edge.
- **Parity, 7 bits, 2 stop bits.** Stimulus: 7E2, write 0x41. Required response: parity bit 0, then two high stop bits. Repeat with odd parity: parity bit 1.
- **Full FIFO and back-to-back.** Stimulus: FIFO_DEPTH=16; write 17 bytes in consecutive cycles while `tx_en`=0. Required response: the 17th write sees `wr_ready`=0 and is dropped; `fifo_level`=16. Then set `tx_en`=1. Required response: 16 frames with exactly one idle cycle between them, then `busy`=0.
- **Divisor and mid-frame config change.** Stimulus: `cfg_div`=3, then change it to 7 mid-frame. Required response: the current frame keeps 64 cycles per bit; the next frame uses 128.
- **Break.** Stimulus: assert `break_req` during a frame. Required response: the frame completes, then `tx`=0 for as long as `break_req` is held. After release, `tx`=1 for at least 1 bit time before the queued byte's start bit.
- **Reset mid-frame.** Stimulus: assert `reset_n`=0 mid-DATA with 3 bytes queued. Required response: `tx`=1 and `fifo_level`=0 immediately; no `tx_done` pulse.
